// File: rtl/stream_req_arbiter.sv
// Arbitrates stream requests from PE_NUM PE controllers onto a shared buffer port.
// The default build is round-robin; defining STREAM_ARB_FIXED_PRIO_EN makes the lowest PE index always win.
module stream_req_arbiter #(
   parameter int PE_NUM  = 4,
   parameter int K_W     = 6,
   parameter int LAYER_W = 3,
   parameter int LEN_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [PE_NUM-1:0]            req_valid,
   input  logic [PE_NUM*K_W-1:0]        req_k,
   input  logic [PE_NUM*LAYER_W-1:0]    req_layer,
   input  logic [PE_NUM*LEN_W-1:0]      req_len,
   output logic [PE_NUM-1:0]            req_ready,
   output logic                         buf_valid,
   input  logic                         buf_ready,
   output logic [K_W-1:0]               buf_k,
   output logic [LAYER_W-1:0]           buf_layer,
   output logic [$clog2(PE_NUM)-1:0]    buf_pe,
   output logic [LEN_W-1:0]             buf_beat,
   output logic                         buf_last,
   output logic                         busy
);
   localparam int PE_W = $clog2(PE_NUM);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] GRANT  = 2'd1;
   localparam logic [1:0] STREAM = 2'd2;

   logic [1:0]         state_reg;
   logic [PE_W-1:0]    winner_reg;
   logic [PE_W-1:0]    winner_next;
   logic [K_W-1:0]     k_reg;
   logic [LAYER_W-1:0] layer_reg;
   logic [LEN_W-1:0]   last_beat_reg;
   logic [LEN_W-1:0]   beat_reg;

   logic [K_W-1:0]     k_arr     [PE_NUM];
   logic [LAYER_W-1:0] layer_arr [PE_NUM];
   logic [LEN_W-1:0]   len_arr   [PE_NUM];

   genvar gi;
   generate
      for (gi = 0; gi < PE_NUM; gi++) begin : g_pe
         assign k_arr[gi]     = req_k[gi*K_W +: K_W];
         assign layer_arr[gi] = req_layer[gi*LAYER_W +: LAYER_W];
         assign len_arr[gi]   = req_len[gi*LEN_W +: LEN_W];
         assign req_ready[gi] = (state_reg == GRANT) && (winner_reg == PE_W'(gi));
      end
   endgenerate

`ifdef STREAM_ARB_FIXED_PRIO_EN
   always_comb begin
      winner_next = '0;
      for (int i = PE_NUM - 1; i >= 0; i--) begin
         if (req_valid[i]) winner_next = PE_W'(i);
      end
   end
`else
   localparam logic [PE_W:0] PE_NUM_X = (PE_W + 1)'(PE_NUM);

   logic [PE_W-1:0] last_grant_reg;
   logic [PE_W:0]   cand;
   logic            found;

   // Search starts one past the previous winner and wraps modulo PE_NUM.
   always_comb begin
      winner_next = last_grant_reg;
      found       = 1'b0;
      cand        = '0;
      for (int i = 1; i <= PE_NUM; i++) begin
         cand = {1'b0, last_grant_reg} + (PE_W + 1)'(i);
         if (cand >= PE_NUM_X) cand = cand - PE_NUM_X;
         if (!found && req_valid[cand[PE_W-1:0]]) begin
            winner_next = cand[PE_W-1:0];
            found       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_reg <= PE_W'(PE_NUM - 1);
      end else if (state_reg == GRANT) begin
         last_grant_reg <= winner_reg;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         winner_reg    <= '0;
         k_reg         <= '0;
         layer_reg     <= '0;
         last_beat_reg <= '0;
         beat_reg      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|req_valid) begin
                  winner_reg <= winner_next;
                  state_reg  <= GRANT;
               end
            end
            GRANT: begin
               // A zero length is streamed as a single beat.
               k_reg         <= k_arr[winner_reg];
               layer_reg     <= layer_arr[winner_reg];
               last_beat_reg <= (len_arr[winner_reg] == '0) ? '0 : len_arr[winner_reg] - LEN_W'(1);
               beat_reg      <= '0;
               state_reg     <= STREAM;
            end
            STREAM: begin
               if (buf_ready) begin
                  if (beat_reg == last_beat_reg) begin
                     beat_reg  <= '0;
                     state_reg <= IDLE;
                  end else begin
                     beat_reg <= beat_reg + LEN_W'(1);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Outputs decode from state only, so an asynchronous reset silences them at once.
   assign buf_valid = (state_reg == STREAM);
   assign buf_k     = buf_valid ? k_reg : '0;
   assign buf_layer = buf_valid ? layer_reg : '0;
   assign buf_pe    = buf_valid ? winner_reg : '0;
   assign buf_beat  = buf_valid ? beat_reg : '0;
   assign buf_last  = buf_valid && (beat_reg == last_beat_reg);
   assign busy      = (state_reg == GRANT) || (state_reg == STREAM);

endmodule

// File: tb/tb_stream_req_arbiter.sv
// Randomized scoreboard bench for stream_req_arbiter: a transaction-level model predicts
// grants and beat streams, and a negedge monitor compares every cycle against it.
module tb_stream_req_arbiter;
   localparam int PE_NUM  = 4;
   localparam int K_W     = 6;
   localparam int LAYER_W = 3;
   localparam int LEN_W   = 8;
   localparam int PE_W    = 2;

   logic                      clk;
   logic                      rst;
   logic [PE_NUM-1:0]         req_valid;
   logic [PE_NUM*K_W-1:0]     req_k;
   logic [PE_NUM*LAYER_W-1:0] req_layer;
   logic [PE_NUM*LEN_W-1:0]   req_len;
   logic [PE_NUM-1:0]         req_ready;
   logic                      buf_valid;
   logic                      buf_ready;
   logic [K_W-1:0]            buf_k;
   logic [LAYER_W-1:0]        buf_layer;
   logic [PE_W-1:0]           buf_pe;
   logic [LEN_W-1:0]          buf_beat;
   logic                      buf_last;
   logic                      busy;

   stream_req_arbiter #(.PE_NUM(PE_NUM), .K_W(K_W), .LAYER_W(LAYER_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_k(req_k), .req_layer(req_layer), .req_len(req_len),
      .req_ready(req_ready),
      .buf_valid(buf_valid), .buf_ready(buf_ready),
      .buf_k(buf_k), .buf_layer(buf_layer), .buf_pe(buf_pe),
      .buf_beat(buf_beat), .buf_last(buf_last), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   typedef struct {
      int pe;
      int k;
      int layer;
      int beat;
      int last;
   } beat_t;

   beat_t exp_q[$];

   // Reference arbitration rule, expressed directly over the request vector.
   function automatic int pick(input logic [PE_NUM-1:0] v, input int last);
`ifdef STREAM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < PE_NUM; i++) if (v[i]) return i;
`else
      for (int off = 1; off <= PE_NUM; off++) begin
         int idx;
         idx = (last + off) % PE_NUM;
         if (v[idx]) return idx;
      end
`endif
      return -1;
   endfunction

   // Monitor / scoreboard
   initial begin : monitor
      logic [PE_NUM-1:0]         prev_valid;
      logic [PE_NUM*K_W-1:0]     prev_k;
      logic [PE_NUM*LAYER_W-1:0] prev_layer;
      logic [PE_NUM*LEN_W-1:0]   prev_len;
      logic                      prev_rst;
      logic                      prev_busy;
      int                        model_last;
      prev_valid = '0; prev_k = '0; prev_layer = '0; prev_len = '0;
      prev_rst = 1'b1; prev_busy = 1'b0; model_last = PE_NUM - 1;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_buf_valid", buf_valid, 0);
            chk("rst_buf_last", buf_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_buf_fields", {buf_k, buf_layer, buf_pe, buf_beat}, 0);
            exp_q.delete();
            model_last = PE_NUM - 1;
            prev_rst = 1'b1;
            prev_busy = 1'b0;
         end else begin
            logic [PE_NUM-1:0] exp_grant;
            logic              exp_valid;
            int                w;
            exp_grant = '0;
            if (!prev_rst && !prev_busy && prev_valid != '0) begin
               int len;
               w = pick(prev_valid, model_last);
               exp_grant[w] = 1'b1;
               model_last = w;
               len = int'(prev_len[w*LEN_W +: LEN_W]);
               if (len == 0) len = 1;
               for (int b = 0; b < len; b++) begin
                  beat_t e;
                  e.pe = w;
                  e.k = int'(prev_k[w*K_W +: K_W]);
                  e.layer = int'(prev_layer[w*LAYER_W +: LAYER_W]);
                  e.beat = b;
                  e.last = (b == len - 1) ? 1 : 0;
                  exp_q.push_back(e);
               end
            end
            chk("req_ready", req_ready, exp_grant);
            exp_valid = (exp_q.size() > 0) && (exp_grant == '0);
            chk("buf_valid", buf_valid, exp_valid);
            chk("busy", busy, (exp_grant != '0) || exp_valid);
            if (buf_valid) begin
               if (exp_q.size() == 0) begin
                  chk("beat_unexpected", 1, 0);
               end else begin
                  chk("buf_pe", buf_pe, exp_q[0].pe);
                  chk("buf_k", buf_k, exp_q[0].k);
                  chk("buf_layer", buf_layer, exp_q[0].layer);
                  chk("buf_beat", buf_beat, exp_q[0].beat);
                  chk("buf_last", buf_last, exp_q[0].last);
                  if (buf_ready) void'(exp_q.pop_front());
               end
            end else begin
               chk("idle_buf_fields", {buf_k, buf_layer, buf_pe, buf_beat, buf_last}, 0);
            end
            prev_busy = (exp_grant != '0) || exp_valid;
            prev_rst = 1'b0;
         end
         prev_valid = req_valid;
         prev_k = req_k;
         prev_layer = req_layer;
         prev_len = req_len;
      end
   end

   // Driver configuration
   int rand_en = 0;
   int req_pct = 0;
   int len_min = 0;
   int len_max = 0;
   int rdy_pct = 100;
   int drop_en = 0;

   task automatic set_req(input int pe, input int k, input int layer, input int len);
      req_valid[pe] = 1'b1;
      req_k[pe*K_W +: K_W] = K_W'(k);
      req_layer[pe*LAYER_W +: LAYER_W] = LAYER_W'(layer);
      req_len[pe*LEN_W +: LEN_W] = LEN_W'(len);
   endtask

   // One clock: requesters release after their ready pulse; inputs change 2 time units after the edge.
   task automatic cycle();
      logic [PE_NUM-1:0] rr;
      @(negedge clk);
      rr = req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < PE_NUM; i++) begin
         if (rr[i]) req_valid[i] = 1'b0;
         if (drop_en != 0 && req_ready[i]) req_valid[i] = 1'b0;
         if (rand_en != 0 && !req_valid[i] && !req_ready[i] &&
             $urandom_range(0, 99) < req_pct)
            set_req(i, $urandom_range(0, 63), $urandom_range(0, 7),
                    $urandom_range(len_min, len_max));
      end
      buf_ready = ($urandom_range(0, 99) < rdy_pct);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((req_valid != '0 || busy || rst) && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_timeout", (n >= budget) ? 1 : 0, 0);
      cycle();
      cycle();
   endtask

   initial begin : stim
      int n;
      rst = 1'b1;
      req_valid = '0; req_k = '0; req_layer = '0; req_len = '0;
      buf_ready = 1'b0;
      repeat (3) cycle();
      rst = 1'b0;
      cycle();

      // Single request from PE2
      set_req(2, 5, 1, 3);
      drain(50);

      // All PEs requesting continuously with one-beat bursts
      rand_en = 1; req_pct = 100; len_min = 1; len_max = 1;
      for (int i = 0; i < PE_NUM; i++) set_req(i, 10 + i, i, 1);
      repeat (30) cycle();
      rand_en = 0;
      drain(100);

      // Backpressure on beat 0 of a two-beat burst
      set_req(0, 7, 2, 2);
      cycle();
      rdy_pct = 0;
      repeat (3) cycle();
      rdy_pct = 100;
      drain(50);

      // Zero-length request
      set_req(1, 9, 3, 0);
      drain(50);

      // Reset during beat 1 of a four-beat burst, then everyone requests
      for (int i = 0; i < PE_NUM; i++) set_req(i, 20 + i, i, 4);
      n = 0;
      while (!(buf_valid && buf_beat == LEN_W'(1)) && n < 40) begin
         cycle();
         n++;
      end
      chk("wait_beat1_timeout", (n >= 40) ? 1 : 0, 0);
      rst = 1'b1;
      #1;
      chk("async_rst_buf_valid", buf_valid, 0);
      chk("async_rst_busy", busy, 0);
      cycle();
      rst = 1'b0;
      for (int i = 0; i < PE_NUM; i++) set_req(i, 30 + i, i, 1);
      drain(100);

      // PE3 drops req_valid while being granted
      drop_en = 1;
      set_req(3, 11, 4, 5);
      drain(50);
      drop_en = 0;

      // Random traffic with random backpressure
      rand_en = 1; req_pct = 30; len_min = 0; len_max = 9; rdy_pct = 70;
      for (int i = 0; i < 1500; i++) begin
         if (i % 300 == 0) drop_en = $urandom_range(0, 1);
         cycle();
      end
      rand_en = 0; drop_en = 0; rdy_pct = 100;
      drain(500);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_req_arbiter.md
STREAM_REQ_ARBITER -- requirements
Module: stream_req_arbiter

Interface
REQ-001 Parameter PE_NUM, default 4: number of requesting PE controllers (2..16).
REQ-002 Parameter K_W, default 6: filter-index width.
REQ-003 Parameter LAYER_W, default 3: conv-layer-number width.
REQ-004 Parameter LEN_W, default 8: burst-length width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 req_valid  input  PE_NUM  per-PE stream request pending.
REQ-008 req_k  input  PE_NUM*K_W  per-PE filter index, PE i at bits [i*K_W +: K_W].
REQ-009 req_layer  input  PE_NUM*LAYER_W  per-PE conv layer number, same packing.
REQ-010 req_len  input  PE_NUM*LEN_W  per-PE burst length in beats, same packing.
REQ-011 req_ready  output  PE_NUM  one-hot one-cycle accept pulse.
REQ-012 buf_valid  output  1  beat request to shared filter/activation buffer.
REQ-013 buf_ready  input  1  buffer accepts beat.
REQ-014 buf_k, buf_layer  output  K_W, LAYER_W  captured request fields, stable for whole burst.
REQ-015 buf_pe  output  clog2(PE_NUM)  index of granted PE.
REQ-016 buf_beat  output  LEN_W  current beat index, 0-based.
REQ-017 buf_last  output  1  high with buf_valid on final beat.
REQ-018 busy  output  1  high in GRANT or STREAM.

Function
REQ-019 FSM states IDLE, GRANT, STREAM; reset state IDLE.
REQ-020 IDLE: if any req_valid bit set, arbitrate combinationally; next state GRANT; else stay IDLE.
REQ-021 GRANT (one cycle): req_ready[winner]=1, all other bits 0; winner's k/layer/len/index captured into registers at end of cycle; next state STREAM.
REQ-022 Winner computed in IDLE, registered, not re-evaluated in GRANT; req_valid deassertion during GRANT does not cancel the burst.
REQ-023 Round-robin: search starts at (last_grant+1) mod PE_NUM, wraps; last_grant resets to PE_NUM-1 so PE 0 wins first.
REQ-024 last_grant updates to winner at GRANT.
REQ-025 STREAM: buf_valid=1 every cycle; beat counter increments on buf_valid&buf_ready.
REQ-026 buf_last=1 when beat counter == captured_len-1.
REQ-027 Handshake with buf_last=1 -> next state IDLE, counter cleared; minimum 1 IDLE cycle between bursts.
REQ-028 req_len==0 treated as 1 beat.
REQ-029 buf_ready low stalls: all buf_* outputs held unchanged.
REQ-030 buf_k/buf_layer/buf_pe/buf_beat are 0 outside STREAM; buf_valid and buf_last 0 outside STREAM.
REQ-031 Requester must hold req_valid and fields until its req_ready pulse; new requests during STREAM wait.
REQ-032 Total request-to-first-beat latency: 2 cycles (IDLE arbitration, GRANT, first beat in STREAM).

Reset
REQ-033 rst assertion immediately (asynchronously) forces IDLE, req_ready=0, buf_valid=0, buf_last=0, busy=0, all captured fields/counter 0, last_grant=PE_NUM-1.
REQ-034 Reset mid-burst abandons the burst; no beat issued after rst rises; first post-reset grant follows REQ-023.

Configuration
REQ-035 STREAM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest PE index wins always, last_grant unused.
REQ-036 STREAM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-023/024; all other behaviour identical.

Verification
REQ-037 Single req: PE2 req_valid, k=5, layer=1, len=3, buf_ready=1 -> req_ready=0b0100 cycle 2, beats 0,1,2 on buf_k=5, buf_layer=1, buf_pe=2, buf_last on beat 2, then IDLE.
REQ-038 All 4 PEs requesting continuously, len=1 -> grant order 0,1,2,3,0 (round-robin); with macro defined -> 0,0,0.
REQ-039 Backpressure: len=2, buf_ready low 3 cycles on beat 0 -> buf_beat stays 0, fields stable, 2 handshakes total.
REQ-040 len=0 from PE1 -> exactly one beat with buf_last=1.
REQ-041 rst pulsed during beat 1 of len=4 burst -> buf_valid 0 same cycle, busy 0, next grant to PE0 when all request.
REQ-042 PE3 drops req_valid during GRANT -> burst still completes full len beats.
